timer_arbiter: RTL and testbench
================================

TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter: TW, 4, width of the time value and of the countdown register.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 enable_1Hz  input  1  one-cycle tick from the divider; the countdown decrements only on cycles where this is high.
REQ-005 reprogram  input  1  synchronized reprogram request; aborts and inhibits timing.
REQ-006 req0 / req1  input  1 each  timer requests; req0 = main traffic FSM, req1 = pedestrian/auxiliary sequencer.
REQ-007 interval0 / interval1  input  2 each  requested interval code for each requester.
REQ-008 param_sel  output  2  interval code presented to the time-parameter store.
REQ-009 param_value  input  TW  time value returned combinationally for param_sel.
REQ-010 grant0 / grant1  output  1 each  timer owned by that requester (one-hot or zero).
REQ-011 expired0 / expired1  output  1 each  one-cycle expiry pulse to the owner.
REQ-012 busy  output  1  high in every state other than IDLE.
REQ-013 count  output  TW  current countdown value (debug/display).

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, RUN and DONE.
REQ-015 IDLE: with reprogram=0 and at least one req high, grant the winner, register param_sel <= the winner's interval, and go to LOAD next cycle.
REQ-016 Arbitration is round-robin. With both reqs high, grant the requester not served last. The "last" flag resets to requester 1, so requester 0 wins the first contention.
REQ-017 The "last" flag updates at grant time, whether or not the timing later completes.
REQ-018 LOAD: capture count <= param_value, then go to RUN. The interval code is latched at grant; later interval changes are ignored.
REQ-019 RUN, enable_1Hz=1 and count <= 1: go to DONE. A value of 0 or 1 therefore expires on the first tick.
REQ-020 RUN, enable_1Hz=1 and count > 1: count <= count - 1.
REQ-021 RUN, enable_1Hz=0: hold.
REQ-022 DONE: assert expired of the owner for exactly one cycle, clear both grants and count, and return to IDLE.
REQ-023 A new grant is possible no earlier than the cycle after DONE, so grant-to-grant spacing is at least 1 idle cycle.
REQ-024 The owner dropping its req in LOAD or RUN SHALL abort to IDLE next cycle: grant cleared, no expired pulse, count cleared.
REQ-025 reprogram=1 in LOAD, RUN or DONE SHALL abort to IDLE with no expired pulse. In IDLE with reprogram=1, no grant is issued.
REQ-026 The abort rules take priority over expiry in the same cycle.
REQ-027 The non-owner's req SHALL be ignored until IDLE; it is never preempted-in.
REQ-028 grant0 and grant1 SHALL never both be 1, and expired0 and expired1 SHALL never both be 1.
REQ-029 An expired pulse SHALL occur only to the requester holding the grant in that cycle.
REQ-030 The count arithmetic is unsigned TW-bit with no wrap-around below 0.

Reset
REQ-031 reset=0 SHALL immediately force: state=IDLE; grant0, grant1, expired0, expired1 and busy = 0; count=0; param_sel=0; last flag = requester 1.
REQ-032 Reset mid-RUN SHALL discard the timing with no expired pulse. Operation resumes on the first clk edge after reset deasserts.

Verification
REQ-033 req0=1, interval0=2, param_value=3, a tick every 4 cycles -> grant0 from cycle 1; expired0 pulses one cycle after the 3rd tick; grant0 low the next cycle.
REQ-034 req0 and req1 rise together after reset -> grant0 first. With both held, grants then alternate: grant1, grant0, ...
REQ-035 param_value=0 and param_value=1 -> expiry on the first enable_1Hz tick after LOAD; count never underflows.
REQ-036 reprogram pulsed mid-RUN with count=2 -> IDLE next cycle; no expired pulse; no grant while reprogram stays high.
REQ-037 Owner drops req during RUN, with the other req pending -> abort to IDLE; the other requester is granted the following cycle; no expired pulse to either.
REQ-038 reset asserted mid-RUN (asynchronous, between edges) -> all outputs 0 immediately; the first request after release wins normally.

Source files
------------

// File: rtl/timer_arbiter.sv
// -----------------------------------------------------------------------------
// timer_arbiter
//   One shared countdown timer arbitrated round-robin between two requesters
//   (req0 = main traffic FSM, req1 = pedestrian/auxiliary sequencer).
//   A grant latches the winner's interval code onto param_sel. The next cycle
//   captures the returned param_value into the countdown. The countdown then
//   decrements on each enable_1Hz tick. On expiry the owner gets a one-cycle
//   expired pulse and the timer returns to IDLE.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   enable_1Hz   one-cycle tick; the countdown only moves when high
//   reprogram    aborts any timing in progress and blocks new grants
//   req0/req1    timer requests
//   interval0/1  interval code of each requester
//   param_sel    interval code presented to the time-parameter store
//   param_value  time value for param_sel (combinational from the store)
//   grant0/1     current owner of the timer (one-hot or zero)
//   expired0/1   one-cycle expiry pulse to the owner
//   busy         high whenever the FSM is not in IDLE
//   count        current countdown value
// -----------------------------------------------------------------------------
module timer_arbiter #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable_1Hz,
  input  logic          reprogram,
  input  logic          req0,
  input  logic          req1,
  input  logic [1:0]    interval0,
  input  logic [1:0]    interval1,
  output logic [1:0]    param_sel,
  input  logic [TW-1:0] param_value,
  output logic          grant0,
  output logic          grant1,
  output logic          expired0,
  output logic          expired1,
  output logic          busy,
  output logic [TW-1:0] count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [TW-1:0] CNT_ZERO = '0;
  localparam logic [TW-1:0] CNT_ONE  = TW'(1);

  state_t        state_reg, state_next;
  logic          owner_reg, owner_next;   // 0 = requester 0, 1 = requester 1
  logic          last_reg, last_next;     // requester served by the last grant
  logic [1:0]    sel_reg, sel_next;
  logic [TW-1:0] count_reg, count_next;

  logic any_req;
  logic winner;
  logic owner_req;
  logic abort;
  logic start;
  logic expire;

  // Only a contention looks at the last flag; a lone requester always wins.
  assign any_req   = req0 | req1;
  assign winner    = (req0 & req1) ? ~last_reg : req1;
  assign owner_req = owner_reg ? req1 : req0;
  // Abort is checked ahead of expiry so that it always takes priority.
  assign abort     = reprogram | ~owner_req;
  assign start     = ~reprogram & any_req;
  // Values 0 and 1 both expire on the first tick; the counter never goes below 0.
  assign expire    = enable_1Hz & (count_reg <= CNT_ONE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = LOAD;
      LOAD: state_next = abort ? IDLE : RUN;
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (expire) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values: owner, round-robin flag, interval code and countdown
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_next = owner_reg;
    last_next  = last_reg;
    sel_next   = sel_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        count_next = CNT_ZERO;
        if (start) begin
          owner_next = winner;
          last_next  = winner;
          sel_next   = winner ? interval1 : interval0;
        end
      end
      LOAD: count_next = abort ? CNT_ZERO : param_value;
      RUN: begin
        if (abort) begin
          count_next = CNT_ZERO;
        end else if (enable_1Hz && !expire) begin
          count_next = count_reg - CNT_ONE;
        end
      end
      DONE:    count_next = CNT_ZERO;
      default: count_next = CNT_ZERO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      sel_reg   <= 2'd0;
      count_reg <= CNT_ZERO;
    end else begin
      owner_reg <= owner_next;
      last_reg  <= last_next;
      sel_reg   <= sel_next;
      count_reg <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The grant is held through DONE, so the expiry pulse goes to the
  // requester that still owns the timer. A reprogram during DONE suppresses
  // the pulse in that same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state_reg != IDLE);
    grant0    = busy & ~owner_reg;
    grant1    = busy &  owner_reg;
    expired0  = (state_reg == DONE) & ~reprogram & ~owner_reg;
    expired1  = (state_reg == DONE) & ~reprogram &  owner_reg;
    param_sel = sel_reg;
    count     = count_reg;
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_timer_arbiter
//   Directed scenarios with literal expectations, followed by randomized
//   traffic. The bench model describes the timer as an owner, a remaining
//   time and two flags (value loaded, expiring). It does not use a state
//   encoding. A single compare process checks every output on every cycle.
// -----------------------------------------------------------------------------
module tb_timer_arbiter;
  localparam int TW = 4;

  logic          clk;
  logic          reset;
  logic          enable_1Hz;
  logic          reprogram;
  logic          req0, req1;
  logic [1:0]    interval0, interval1;
  logic [1:0]    param_sel;
  logic [TW-1:0] param_value;
  logic          grant0, grant1, expired0, expired1, busy;
  logic [TW-1:0] count;

  logic [TW-1:0] p_table [4];
  assign param_value = p_table[param_sel];

  timer_arbiter #(.TW(TW)) dut (
    .clk(clk), .reset(reset), .enable_1Hz(enable_1Hz), .reprogram(reprogram),
    .req0(req0), .req1(req1), .interval0(interval0), .interval1(interval1),
    .param_sel(param_sel), .param_value(param_value),
    .grant0(grant0), .grant1(grant1), .expired0(expired0), .expired1(expired1),
    .busy(busy), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_owner;   // -1 = timer free
  int         m_cnt;
  bit         m_loaded;
  bit         m_done;
  logic [1:0] m_sel;
  logic       m_last;
  logic       m_win;
  logic       m_r;

  assign m_win = (req0 && req1) ? ~m_last : ~req0;
  assign m_r   = (m_owner == 0) ? req0 : req1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner <= -1; m_cnt <= 0; m_loaded <= 0; m_done <= 0; m_sel <= 2'd0; m_last <= 1'b1;
    end else if (m_done) begin
      m_owner <= -1; m_cnt <= 0; m_loaded <= 0; m_done <= 0;
    end else if (m_owner < 0) begin
      if (!reprogram && (req0 || req1)) begin
        m_owner  <= m_win ? 1 : 0;
        m_last   <= m_win;
        m_sel    <= m_win ? interval1 : interval0;
        m_loaded <= 0;
      end
    end else if (reprogram || !m_r) begin
      m_owner <= -1; m_cnt <= 0; m_loaded <= 0;
    end else if (!m_loaded) begin
      m_cnt    <= int'(p_table[m_sel]);
      m_loaded <= 1;
    end else if (enable_1Hz) begin
      if (m_cnt <= 1) m_done <= 1;
      else            m_cnt  <= m_cnt - 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    #2;
    if (chk_on) begin
      check("grant0",    32'(grant0),    32'(m_owner == 0));
      check("grant1",    32'(grant1),    32'(m_owner == 1));
      check("busy",      32'(busy),      32'(m_owner >= 0));
      check("expired0",  32'(expired0),  32'(m_done && m_owner == 0 && !reprogram));
      check("expired1",  32'(expired1),  32'(m_done && m_owner == 1 && !reprogram));
      check("count",     32'(count),     32'(m_cnt));
      check("param_sel", 32'(param_sel), 32'(m_sel));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req0 = 0; req1 = 0; enable_1Hz = 0; reprogram = 0; interval0 = 0; interval1 = 0;
    #1;
    check("rst_out", {26'd0, grant0, grant1, expired0, expired1, busy, |count}, 32'd0);
    check("rst_sel", 32'(param_sel), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  int n_exp, first_exp, g_cyc, e_cyc, ns;
  int seq [8];
  logic pg0, pg1;

  initial begin
    reset = 1'b0; req0 = 0; req1 = 0; enable_1Hz = 0; reprogram = 0;
    interval0 = 0; interval1 = 0;
    for (int k = 0; k < 4; k++) p_table[k] = '0;
    do_reset();
    chk_on = 1'b1;

    // Basic timing: value 3, a tick every 4 cycles; interval change mid-run is ignored.
    p_table[2] = 4'd3; p_table[1] = 4'd9;
    n_exp = 0; first_exp = -1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) begin req0 = 1; interval0 = 2'd2; end
      if (i == 5) interval0 = 2'd1;
      if (i == 13) req0 = 0;
      enable_1Hz = (i % 4 == 3);
      #3;
      if (expired0) begin n_exp++; if (first_exp < 0) first_exp = i; end
      if (i == 0)  check("r33_idle_c0", 32'(grant0), 32'd0);
      if (i == 1)  check("r33_grant_c1", 32'(grant0), 32'd1);
      if (i == 2)  check("r33_load3", 32'(count), 32'd3);
      if (i == 12) check("r33_exp", 32'(expired0), 32'd1);
      if (i == 13) check("r33_grant_off", 32'(grant0), 32'd0);
    end
    check("r33_exp_cycle", 32'(first_exp), 32'd12);
    check("r33_exp_count", 32'(n_exp), 32'd1);

    // Round-robin under continuous contention.
    do_reset();
    for (int k = 0; k < 4; k++) p_table[k] = 4'd1;
    ns = 0; pg0 = 0; pg1 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) begin req0 = 1; req1 = 1; enable_1Hz = 1; end
      #3;
      if (grant0 && !pg0 && ns < 8) begin seq[ns] = 0; ns++; end
      if (grant1 && !pg1 && ns < 8) begin seq[ns] = 1; ns++; end
      pg0 = grant0; pg1 = grant1;
    end
    check("r34_ngrants_ge4", 32'(ns >= 4), 32'd1);
    if (ns >= 4) begin
      check("r34_first0",  32'(seq[0]), 32'd0);
      check("r34_second1", 32'(seq[1]), 32'd1);
      check("r34_third0",  32'(seq[2]), 32'd0);
      check("r34_fourth1", 32'(seq[3]), 32'd1);
    end

    // Values 0 and 1 expire on the first tick after LOAD.
    for (int v = 0; v < 2; v++) begin
      do_reset();
      p_table[v] = 4'(v);
      g_cyc = -1; e_cyc = -1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (i == 0) begin req0 = 1; interval0 = 2'(v); enable_1Hz = 1; end
        if (i == 4) req0 = 0;
        #3;
        if (grant0 && g_cyc < 0) g_cyc = i;
        if (expired0 && e_cyc < 0) e_cyc = i;
        if (i == 2) check("r35_run_count", 32'(count), 32'(v));
      end
      check("r35_latency", 32'(e_cyc - g_cyc), 32'd2);
    end

    // Reprogram mid-RUN with count = 2.
    do_reset();
    p_table[3] = 4'd2;
    n_exp = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) begin req0 = 1; interval0 = 2'd3; end
      if (i == 3) begin reprogram = 1; enable_1Hz = 1; end
      if (i == 9) begin reprogram = 0; enable_1Hz = 0; end
      #3;
      if (expired0 || expired1) n_exp++;
      if (i == 2) check("r36_count2", 32'(count), 32'd2);
      if (i == 4) check("r36_idle", {29'd0, busy, grant0, |count}, 32'd0);
      if (i >= 5 && i <= 9) check("r36_no_grant", 32'(grant0 | grant1), 32'd0);
      if (i == 10) check("r36_regrant", 32'(grant0), 32'd1);
    end
    check("r36_no_expiry", 32'(n_exp), 32'd0);
    req0 = 0;

    // Owner drops its request during RUN while the other waits.
    do_reset();
    p_table[0] = 4'd5;
    n_exp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin req0 = 1; interval0 = 2'd0; end
      if (i == 3) req1 = 1;
      if (i == 4) req0 = 0;
      #3;
      if (expired0 || expired1) n_exp++;
      if (i == 3) check("r37_no_preempt", 32'(grant1), 32'd0);
      if (i == 5) check("r37_abort", {30'd0, busy, grant0}, 32'd0);
      if (i == 6) check("r37_other_granted", 32'(grant1), 32'd1);
    end
    check("r37_no_expiry", 32'(n_exp), 32'd0);

    // Asynchronous reset between edges during RUN.
    do_reset();
    p_table[0] = 4'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) req0 = 1;
      #3;
      if (i == 2) check("r38_running", 32'(busy), 32'd1);
    end
    reset = 1'b0;
    #1;
    check("r38_async_clear", {26'd0, grant0, grant1, expired0, expired1, busy, |count}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1; req0 = 1; req1 = 1;
    @(negedge clk);
    #3;
    check("r38_first_after", {30'd0, grant0, grant1}, 32'd2);
    req0 = 0; req1 = 0;

    // Randomized traffic checked by the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i % 150 == 0)
        for (int k = 0; k < 4; k++) p_table[k] = 4'($urandom_range(15));
      if ($urandom_range(9) == 0) req0 = ~req0;
      if ($urandom_range(9) == 0) req1 = ~req1;
      enable_1Hz = ($urandom_range(2) == 0);
      reprogram  = ($urandom_range(24) == 0);
      interval0  = 2'($urandom_range(3));
      interval1  = 2'($urandom_range(3));
      if ($urandom_range(499) == 0) begin
        #3 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end

    @(negedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
